// File: rtl/array_shift_down.sv
// rtl/array_shift_down.sv - heap array shift-down engine (optional ARRAY_SHIFT_DOWN_CLEAR_EN clears vacated top slot)
module array_shift_down #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 10,
    parameter int NArrays            = 20
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(NArrays)-1:0]    cmd_array,
    input  logic [$clog2(NArea)-1:0]      cmd_pos,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [MemoryElementWidth-1:0] rsp_value,
    output logic                          rsp_error,
    input  logic                          wr_en,
    input  logic [$clog2(NArrays)-1:0]    wr_array,
    input  logic [$clog2(NArea)-1:0]      wr_index,
    input  logic [MemoryElementWidth-1:0] wr_data,
    input  logic                          sz_en,
    input  logic [$clog2(NArrays)-1:0]    sz_array,
    input  logic [MemoryElementWidth-1:0] sz_data,
    input  logic [$clog2(NArrays)-1:0]    rd_array,
    input  logic [$clog2(NArea)-1:0]      rd_index,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic [MemoryElementWidth-1:0] rd_size
);
    localparam int W      = MemoryElementWidth;
    localparam int AA     = $clog2(NArrays);
    localparam int AI     = $clog2(NArea);
    localparam int HEAP_N = NArrays * NArea;
    localparam int HA     = $clog2(HEAP_N);

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, RESP} state_t;

    state_t         state_q, state_d;
    logic [AA-1:0]  array_q, array_d;
    logic [AI-1:0]  idx_q, idx_d;
    logic [W-1:0]   size_q, size_d;
    logic [W-1:0]   bound_q, bound_d;
    logic [W-1:0]   rsp_value_q, rsp_value_d;
    logic           rsp_error_q, rsp_error_d;

    logic [W-1:0]   heap_mem [HEAP_N];
    logic [W-1:0]   sizes_q [NArrays];

    logic           heap_we;
    logic [HA-1:0]  heap_waddr;
    logic [W-1:0]   heap_wdata;
    logic           sz_we;
    logic [AA-1:0]  sz_waddr;
    logic [W-1:0]   sz_wdata;
    logic [W-1:0]   cur_size;
    logic           arr_ok;

    function automatic logic [HA-1:0] haddr(input logic [AA-1:0] a, input logic [AI-1:0] i);
        return HA'(int'(a) * NArea + int'(i));
    endfunction

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_value = rsp_value_q;
    assign rsp_error = rsp_error_q;

    assign arr_ok   = int'(array_q) < NArrays;
    assign cur_size = arr_ok ? sizes_q[array_q] : '0;

    assign rd_data = (int'(rd_array) < NArrays && int'(rd_index) < NArea)
                     ? heap_mem[haddr(rd_array, rd_index)] : '0;
    assign rd_size = (int'(rd_array) < NArrays) ? sizes_q[rd_array] : '0;

    always_comb begin
        state_d     = state_q;
        array_d     = array_q;
        idx_d       = idx_q;
        size_d      = size_q;
        bound_d     = bound_q;
        rsp_value_d = rsp_value_q;
        rsp_error_d = rsp_error_q;
        heap_we     = 1'b0;
        heap_waddr  = haddr(array_q, idx_q);
        heap_wdata  = '0;
        sz_we       = 1'b0;
        sz_waddr    = array_q;
        sz_wdata    = '0;
        case (state_q)
            IDLE: begin
                if (wr_en && int'(wr_array) < NArrays && int'(wr_index) < NArea) begin
                    heap_we    = 1'b1;
                    heap_waddr = haddr(wr_array, wr_index);
                    heap_wdata = wr_data;
                end
                if (sz_en && int'(sz_array) < NArrays) begin
                    sz_we    = 1'b1;
                    sz_waddr = sz_array;
                    sz_wdata = sz_data;
                end
                if (cmd_valid) begin
                    array_d = cmd_array;
                    idx_d   = cmd_pos;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Positions beyond the area are rejected even if the stored size is larger
                if (!arr_ok || W'(idx_q) >= cur_size || int'(idx_q) >= NArea) begin
                    rsp_error_d = 1'b1;
                    rsp_value_d = '0;
                    state_d     = RESP;
                end else begin
                    rsp_error_d = 1'b0;
                    rsp_value_d = heap_mem[haddr(array_q, idx_q)];
                    size_d      = cur_size;
                    bound_d     = (int'(cur_size) > NArea) ? W'(NArea) : cur_size;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (W'(idx_q) + W'(1) < bound_q) begin
                    heap_we    = 1'b1;
                    heap_wdata = heap_mem[haddr(array_q, idx_q + AI'(1))];
                    idx_d      = idx_q + AI'(1);
                end else begin
                    sz_we    = 1'b1;
                    sz_wdata = size_q - W'(1);
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
                    heap_we    = 1'b1;
                    heap_waddr = haddr(array_q, AI'(bound_q - W'(1)));
                    heap_wdata = '0;
`endif
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            array_q     <= '0;
            idx_q       <= '0;
            size_q      <= '0;
            bound_q     <= '0;
            rsp_value_q <= '0;
            rsp_error_q <= 1'b0;
            for (int i = 0; i < NArrays; i++) begin
                sizes_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            array_q     <= array_d;
            idx_q       <= idx_d;
            size_q      <= size_d;
            bound_q     <= bound_d;
            rsp_value_q <= rsp_value_d;
            rsp_error_q <= rsp_error_d;
            if (sz_we) begin
                sizes_q[sz_waddr] <= sz_wdata;
            end
        end
    end

    // Heap storage is not reset; a reset cycle suppresses any in-flight move
    always_ff @(posedge clock) begin
        if (reset && heap_we) begin
            heap_mem[heap_waddr] <= heap_wdata;
        end
    end
endmodule

// File: tb/tb_array_shift_down.sv
// tb/tb_array_shift_down.sv - randomized model-checked bench for array_shift_down
module tb_array_shift_down;
    localparam int W  = 12;
    localparam int NA = 10;
    localparam int NR = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_array = '0;
    logic [3:0]    cmd_pos = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_value;
    logic          rsp_error;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_array = '0;
    logic [3:0]    wr_index = '0;
    logic [W-1:0]  wr_data = '0;
    logic          sz_en = 1'b0;
    logic [4:0]    sz_array = '0;
    logic [W-1:0]  sz_data = '0;
    logic [4:0]    rd_array = '0;
    logic [3:0]    rd_index = '0;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  rd_size;

    array_shift_down dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_array(cmd_array), .cmd_pos(cmd_pos),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value), .rsp_error(rsp_error),
        .wr_en(wr_en), .wr_array(wr_array), .wr_index(wr_index), .wr_data(wr_data),
        .sz_en(sz_en), .sz_array(sz_array), .sz_data(sz_data),
        .rd_array(rd_array), .rd_index(rd_index), .rd_data(rd_data), .rd_size(rd_size)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int m_heap [NR][NA];
    int m_size [NR];

    bit chk_on    = 1'b0;
    bit exp_ready = 1'b1;
    bit exp_valid = 1'b0;
    int exp_value = 0;
    bit exp_err   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("cmd_ready", int'(cmd_ready), int'(exp_ready));
            chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
            if (exp_valid) begin
                chk("rsp_value", int'(rsp_value), exp_value);
                chk("rsp_error", int'(rsp_error), int'(exp_err));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_elem(input int a, input int i, input int d);
        wr_en = 1'b1; wr_array = 5'(a); wr_index = 4'(i); wr_data = W'(d);
        step();
        wr_en = 1'b0;
        m_heap[a][i] = d;
    endtask

    task automatic load_size(input int a, input int s);
        sz_en = 1'b1; sz_array = 5'(a); sz_data = W'(s);
        step();
        sz_en = 1'b0;
        m_size[a] = s;
    endtask

    task automatic check_array(input int a);
        for (int i = 0; i < NA; i++) begin
            rd_array = 5'(a); rd_index = 4'(i);
            #1;
            chk($sformatf("rd_data[%0d][%0d]", a, i), int'(rd_data), m_heap[a][i]);
        end
        chk($sformatf("rd_size[%0d]", a), int'(rd_size), m_size[a]);
        step();
    endtask

    // Issue one command from IDLE; new_sz >= 0 also writes the size in the accept cycle
    task automatic do_cmd(input int a, input int p, input int hold, input bit junk,
                          input int new_sz, output int obs_lat, output int obs_val);
        int s;
        int lat;
        cmd_valid = 1'b1; cmd_array = 5'(a); cmd_pos = 4'(p);
        if (new_sz >= 0) begin
            sz_en = 1'b1; sz_array = 5'(a); sz_data = W'(new_sz);
            m_size[a] = new_sz;
        end
        s = m_size[a];
        exp_err   = (p >= s);
        exp_value = exp_err ? 0 : m_heap[a][p];
        lat       = exp_err ? 2 : 3 + (s - 1 - p);
        obs_lat = -1;
        obs_val = -1;
        step();
        cmd_valid = 1'b0;
        sz_en     = 1'b0;
        exp_ready = 1'b0;
        for (int m = 0; m <= lat - 1 + hold; m++) begin
            exp_valid = (m >= lat - 1);
            rsp_ready = (m >= lat - 1 + hold);
            wr_en = junk; wr_array = 5'(a); wr_index = 4'($urandom_range(0, NA - 1));
            wr_data = W'($urandom_range(0, 4095));
            sz_en = junk; sz_array = 5'(a); sz_data = W'($urandom_range(0, 4095));
            if (rsp_valid && obs_lat < 0) begin
                obs_lat = m + 1;
                obs_val = int'(rsp_value);
            end
            step();
        end
        wr_en = 1'b0; sz_en = 1'b0; rsp_ready = 1'b0;
        exp_ready = 1'b1;
        exp_valid = 1'b0;
        if (!exp_err) begin
            for (int i = p; i < s - 1; i++) m_heap[a][i] = m_heap[a][i + 1];
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
            m_heap[a][s - 1] = 0;
`endif
            m_size[a] = s - 1;
        end
        chk("latency", obs_lat, lat);
    endtask

    initial begin
        int lat;
        int val;
        int a;
        int p;
        int ns;
        for (int r = 0; r < NR; r++) m_size[r] = 0;
        step();
        step();
        reset = 1'b1;
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset rsp_valid", int'(rsp_valid), 0);
        chk("reset rsp_value", int'(rsp_value), 0);
        chk("reset rsp_error", int'(rsp_error), 0);
        chk_on = 1'b1;
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < NA; i++)
                load_elem(r, i, $urandom_range(0, 4095));
        check_array(7);

        // Array 1 = [0,1,2], remove pos 0
        for (int i = 0; i < 3; i++) load_elem(1, i, i);
        load_size(1, 3);
        do_cmd(1, 0, 0, 1'b0, -1, lat, val);
        chk("t1 lat", lat, 5);
        chk("t1 value", val, 0);
        rd_array = 5'd1; rd_index = 4'd0; #1;
        chk("t1 slot0", int'(rd_data), 1);
        rd_index = 4'd1; #1;
        chk("t1 slot1", int'(rd_data), 2);
        chk("t1 size", int'(rd_size), 2);
        check_array(1);

        // Array 1 = [99,0,1], remove last element
        load_elem(1, 0, 99); load_elem(1, 1, 0); load_elem(1, 2, 1);
        load_size(1, 3);
        do_cmd(1, 2, 0, 1'b0, -1, lat, val);
        chk("t2 lat", lat, 3);
        chk("t2 value", val, 1);
        rd_array = 5'd1; rd_index = 4'd2; #1;
`ifdef ARRAY_SHIFT_DOWN_CLEAR_EN
        chk("t2 slot2", int'(rd_data), 0);
`else
        chk("t2 slot2", int'(rd_data), 1);
`endif
        chk("t2 size", int'(rd_size), 2);
        check_array(1);

        // Error cases: pos == size, and empty array
        load_size(3, 3);
        do_cmd(3, 3, 0, 1'b0, -1, lat, val);
        chk("t3 lat", lat, 2);
        chk("t3 value", val, 0);
        check_array(3);
        do_cmd(4, 0, 0, 1'b0, -1, lat, val);
        chk("t3b lat", lat, 2);
        check_array(4);

        // Full array 0..9
        for (int i = 0; i < NA; i++) load_elem(2, i, i);
        load_size(2, 10);
        do_cmd(2, 0, 0, 1'b0, -1, lat, val);
        chk("t4 lat", lat, 12);
        chk("t4 value", val, 0);
        for (int i = 0; i < 9; i++) begin
            rd_array = 5'd2; rd_index = 4'(i); #1;
            chk("t4 content", int'(rd_data), i + 1);
        end
        chk("t4 size", int'(rd_size), 9);
        check_array(2);

        // Backpressure with ignored writes while busy
        load_size(6, 5);
        do_cmd(6, 1, 5, 1'b1, -1, lat, val);
        check_array(6);

        // Size written in the accept cycle is seen by CHECK
        do_cmd(8, 2, 0, 1'b0, 4, lat, val);
        chk("same-cycle size err", int'(exp_err), 0);
        check_array(8);

        // Reset during SHIFT
        for (int i = 0; i < NA; i++) load_elem(5, i, i);
        load_size(5, 10);
        cmd_valid = 1'b1; cmd_array = 5'd5; cmd_pos = 4'd0;
        step();
        cmd_valid = 1'b0; exp_ready = 1'b0; exp_valid = 1'b0;
        step();
        step();
        step();
        chk_on = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid-reset cmd_ready", int'(cmd_ready), 1);
        chk("mid-reset rsp_valid", int'(rsp_valid), 0);
        m_heap[5][0] = 1;
        m_heap[5][1] = 2;
        for (int r = 0; r < NR; r++) m_size[r] = 0;
        exp_ready = 1'b1;
        chk_on = 1'b1;
        check_array(5);
        load_size(5, 4);
        do_cmd(5, 1, 0, 1'b0, -1, lat, val);
        chk("post-reset value", val, 2);
        check_array(5);

        // Randomized commands
        for (int it = 0; it < 60; it++) begin
            a = $urandom_range(0, NR - 1);
            if ($urandom_range(0, 3) == 0)
                load_elem(a, $urandom_range(0, NA - 1), $urandom_range(0, 4095));
            ns = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NA)) : -1;
            if (m_size[a] == 0 && ns < 0) ns = $urandom_range(0, NA);
            p = $urandom_range(0, NA - 1);
            do_cmd(a, p, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ns, lat, val);
            check_array(a);
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
